// File: rtl/ysyx_23060180_mem_arbiter.sv
// rtl/ysyx_23060180_mem_arbiter.sv - single-port memory arbiter between IFU and LSU
// One outstanding transaction, LSU priority with IFU starvation guard, response timeout.
module ysyx_23060180_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_wdata,
  input  logic [3:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          owner_lsu;
  logic [3:0]    starve_cnt;
  logic [CW-1:0] timeout_cnt;

  logic          lsu_win;
  logic          ifu_win;
  logic          timeout_hit;
  logic          resp_fire;
  logic          resp_err_next;
  logic [31:0]   resp_data_next;

  // IFU overrides LSU priority once it has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    lsu_win        = lsu_req_valid && !(ifu_req_valid && (starve_cnt == 4'(STARVE_LIMIT)));
    ifu_win        = ifu_req_valid && !lsu_win;
    timeout_hit    = (TIMEOUT_CYCLES != 0) && (timeout_cnt == CW'(TIMEOUT_CYCLES - 1));
    resp_fire      = (state == WAIT) && (mem_resp_valid || timeout_hit);
    resp_err_next  = !mem_resp_valid;
    resp_data_next = mem_resp_valid ? mem_resp_rdata : 32'd0;
  end

  assign ifu_req_ready = (state == IDLE) && ifu_win;
  assign lsu_req_ready = (state == IDLE) && lsu_win;
  assign mem_req_valid = (state == ISSUE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner_lsu      <= 1'b0;
      starve_cnt     <= 4'd0;
      timeout_cnt    <= '0;
      mem_req_addr   <= 32'd0;
      mem_req_wen    <= 1'b0;
      mem_req_wdata  <= 32'd0;
      mem_req_wmask  <= 4'd0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_rdata <= 32'd0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_rdata <= 32'd0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_win || ifu_win) begin
            owner_lsu     <= lsu_win;
            mem_req_addr  <= lsu_win ? lsu_req_addr : ifu_req_addr;
            mem_req_wen   <= lsu_win && lsu_req_wen;
            mem_req_wdata <= lsu_win ? lsu_req_wdata : 32'd0;
            mem_req_wmask <= lsu_win ? lsu_req_wmask : 4'd0;
            starve_cnt    <= (lsu_win && ifu_req_valid) ? starve_cnt + 4'd1 : 4'd0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            timeout_cnt <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (resp_fire) begin
            if (owner_lsu) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_rdata <= resp_data_next;
              lsu_resp_err   <= resp_err_next;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_rdata <= resp_data_next;
              ifu_resp_err   <= resp_err_next;
            end
            state <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// tb/tb_ysyx_23060180_mem_arbiter.sv - randomized bench with transaction-level model for the mem arbiter
module tb_ysyx_23060180_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        busy;

  ysyx_23060180_mem_arbiter #(
    .STARVE_LIMIT  (STARVE_LIMIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_rdata(ifu_resp_rdata),
    .ifu_resp_err  (ifu_resp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_req_addr  (lsu_req_addr),
    .lsu_req_wen   (lsu_req_wen),
    .lsu_req_wdata (lsu_req_wdata),
    .lsu_req_wmask (lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err  (lsu_resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // transaction-level model: one outstanding request, response due at a known cycle
  bit          outs, macc, pend;
  int          pulse_cyc, resp_cyc, starve, hs_cyc, act_lat;
  bit          p_lsu, p_err, act_err;
  logic [31:0] p_data, resp_data, last_ifu, last_lsu;
  bit          r_lsu, r_wen;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_wmask;

  bit          ifu_v, lsu_v, lsu_wen;
  logic [31:0] ifu_a, lsu_a, lsu_wd;
  logic [3:0]  lsu_wm;

  int          ifu_pct, lsu_pct, rdy_pct, force_d, hold;
  bit          noise, force_data_en;
  logic [31:0] force_data;
  bit          grant_log[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(99));
    if (r < 75) return int'($urandom_range(6, 1));
    if (r < 90) return int'($urandom_range(16, 7));
    return int'($urandom_range(18, 17));
  endfunction

  task automatic model_clear();
    outs = 0; macc = 0; pend = 0; resp_cyc = -1; pulse_cyc = -1;
    starve = 0; last_ifu = 0; last_lsu = 0;
    ifu_v = 0; lsu_v = 0; hold = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_flags", 32'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, ifu_resp_err,
                            lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_req_wen,
                            busy, mem_req_wmask}), 32'd0);
    chk("reset_ifu_rdata", ifu_resp_rdata, 32'd0);
    chk("reset_lsu_rdata", lsu_resp_rdata, 32'd0);
    chk("reset_mem_addr", mem_req_addr, 32'd0);
    chk("reset_mem_wdata", mem_req_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    cyc++;
  endtask

  // one clock cycle: called at negedge, drives inputs, checks, advances the model
  task automatic step();
    bit pulse_now, in_wait, free, lw, iw;
    int d;
    pulse_now = pend && (pulse_cyc == cyc);
    if (!ifu_v && (int'($urandom_range(99)) < ifu_pct)) begin
      ifu_v = 1; ifu_a = $urandom;
    end
    if (!lsu_v && (int'($urandom_range(99)) < lsu_pct)) begin
      lsu_v = 1; lsu_a = $urandom; lsu_wen = 1'($urandom_range(1));
      lsu_wd = $urandom; lsu_wm = 4'($urandom);
    end
    ifu_req_valid = ifu_v;
    ifu_req_addr  = ifu_a;
    lsu_req_valid = lsu_v;
    lsu_req_addr  = lsu_a;
    lsu_req_wen   = lsu_wen;
    lsu_req_wdata = lsu_wd;
    lsu_req_wmask = lsu_wm;
    if (hold > 0) begin
      mem_req_ready = 1'b0;
      hold--;
    end else begin
      mem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    end
    if (pulse_now) begin
      outs = 0; macc = 0; pend = 0;
    end
    in_wait = outs && macc;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = $urandom;
    if (resp_cyc == cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = resp_data;
      resp_cyc = -1;
    end else if (noise && !in_wait && ($urandom_range(9) == 0)) begin
      mem_resp_valid = 1'b1;
    end
    #1;
    if (pulse_now) begin
      if (p_lsu) last_lsu = p_data;
      else last_ifu = p_data;
    end
    if (ifu_resp_valid || lsu_resp_valid) begin
      act_lat = cyc - hs_cyc;
      act_err = ifu_resp_err | lsu_resp_err;
    end
    chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(pulse_now && !p_lsu));
    chk("ifu_resp_err", 32'(ifu_resp_err), 32'(pulse_now && !p_lsu && p_err));
    chk("ifu_resp_rdata", ifu_resp_rdata, last_ifu);
    chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(pulse_now && p_lsu));
    chk("lsu_resp_err", 32'(lsu_resp_err), 32'(pulse_now && p_lsu && p_err));
    chk("lsu_resp_rdata", lsu_resp_rdata, last_lsu);
    chk("busy", 32'(busy), 32'(outs));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(outs && !macc));
    if (outs && !macc) begin
      chk("mem_req_addr", mem_req_addr, r_addr);
      chk("mem_req_wen", 32'(mem_req_wen), 32'(r_wen));
      chk("mem_req_wdata", mem_req_wdata, r_wdata);
      chk("mem_req_wmask", 32'(mem_req_wmask), 32'(r_wmask));
    end
    free = !outs;
    lw = free && lsu_v && !(ifu_v && (starve == STARVE_LIMIT));
    iw = free && ifu_v && !lw;
    chk("ifu_req_ready", 32'(ifu_req_ready), 32'(iw));
    chk("lsu_req_ready", 32'(lsu_req_ready), 32'(lw));
    if ((ifu_req_ready && ifu_req_valid) || (lsu_req_ready && lsu_req_valid)) begin
      grant_log.push_back(lsu_req_ready);
      hs_cyc = cyc;
    end
    if (outs && !macc && mem_req_ready) begin
      macc = 1;
      d = (force_d > 0) ? force_d : pick_delay();
      resp_data = force_data_en ? force_data : $urandom;
      if (d <= TIMEOUT) begin
        resp_cyc = cyc + d; pulse_cyc = cyc + d + 1; p_data = resp_data; p_err = 0;
      end else begin
        resp_cyc = (d <= TIMEOUT + 2) ? cyc + d : -1;
        pulse_cyc = cyc + TIMEOUT + 1; p_data = 32'd0; p_err = 1;
      end
      pend = 1;
    end
    if (lw || iw) begin
      r_lsu = lw;
      starve = (lw && ifu_v) ? starve + 1 : 0;
      if (lw) begin
        r_addr = lsu_a; r_wen = lsu_wen; r_wdata = lsu_wd; r_wmask = lsu_wm; lsu_v = 0;
      end else begin
        r_addr = ifu_a; r_wen = 0; r_wdata = 32'd0; r_wmask = 4'd0; ifu_v = 0;
      end
      p_lsu = r_lsu;
      outs = 1; macc = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    ifu_a = 0; lsu_a = 0; lsu_wen = 0; lsu_wd = 0; lsu_wm = 0;
    r_lsu = 0; r_wen = 0; r_addr = 0; r_wdata = 0; r_wmask = 0;
    p_lsu = 0; p_err = 0; p_data = 0; resp_data = 0; hs_cyc = 0; act_lat = 0; act_err = 0;
    ifu_pct = 0; lsu_pct = 0; rdy_pct = 100; force_d = 1; noise = 0;
    force_data_en = 1; force_data = 32'h0010_0073;
    model_clear();
    @(negedge clk);
    do_reset();

    // IFU alone
    ifu_v = 1; ifu_a = 32'h8000_0000;
    repeat (5) step();
    chk("ifu_alone_rdata", ifu_resp_rdata, 32'h0010_0073);
    chk("ifu_alone_latency", 32'(act_lat), 32'd3);
    force_data_en = 0;

    // simultaneous LSU write and IFU read
    grant_log.delete();
    ifu_v = 1; ifu_a = 32'h8000_0100;
    lsu_v = 1; lsu_a = 32'h8000_1000; lsu_wen = 1; lsu_wd = 32'hDEAD_BEEF; lsu_wm = 4'hF;
    repeat (10) step();
    chk("simul_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) chk("simul_grant_order", 32'({grant_log[0], grant_log[1]}), 32'd2);

    // backpressure: LSU wins, IFU waits, memory stalls 5 cycles in ISSUE
    hold = 6;
    lsu_v = 1; lsu_a = $urandom; lsu_wen = 1; lsu_wd = $urandom; lsu_wm = 4'h3;
    ifu_v = 1; ifu_a = $urandom;
    repeat (9) step();
    chk("backpressure_latency", 32'(act_lat), 32'd8);
    repeat (6) step();

    // reset in WAIT, then a clean fetch
    force_d = 10;
    ifu_v = 1; ifu_a = $urandom;
    repeat (4) step();
    do_reset();
    repeat (12) step();
    force_d = 1;
    ifu_v = 1; ifu_a = 32'h8000_0004;
    repeat (5) step();
    chk("post_reset_latency", 32'(act_lat), 32'd3);

    // starvation pattern
    do_reset();
    grant_log.delete();
    ifu_pct = 100; lsu_pct = 100;
    repeat (45) step();
    got = 32'd0;
    for (int i = 0; i < 10; i++) got = {got[30:0], (i < grant_log.size()) ? grant_log[i] : 1'b0};
    chk("starve_pattern", got, 32'b11_1101_1110);

    // timeout with a late response, then a normal read
    ifu_pct = 0; lsu_pct = 0;
    repeat (12) step();
    lsu_v = 1; lsu_a = 32'h8000_2000; lsu_wen = 0; lsu_wd = 0; lsu_wm = 0;
    force_d = 18;
    repeat (20) step();
    chk("timeout_latency", 32'(act_lat), 32'd18);
    chk("timeout_err", 32'(act_err), 32'd1);
    chk("timeout_rdata", lsu_resp_rdata, 32'd0);
    force_d = 1;
    lsu_v = 1; lsu_a = $urandom;
    repeat (5) step();
    chk("after_timeout_err", 32'(act_err), 32'd0);
    chk("after_timeout_latency", 32'(act_lat), 32'd3);

    // randomized traffic
    force_d = 0; ifu_pct = 50; lsu_pct = 50; rdy_pct = 70; noise = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
